// File: rtl/result_checker_pkg.sv
// result_checker_pkg: FSM state encodings and state width shared by the checker slice
package result_checker_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_FAIL = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/result_checker_if.sv
// result_checker_if: sample stream into the checker and registered status out of it
interface result_checker_if
    import result_checker_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 16
);
    logic                 i_valid;
    logic [DATAWIDTH-1:0] i_d_meas;
    logic [DATAWIDTH-1:0] i_d_ref;
    logic                 o_err;
    logic                 o_done;
    logic                 o_pass;
    logic [STATE_W-1:0]   o_state;
    logic [CNTWIDTH-1:0]  o_check_cnt;
    logic [CNTWIDTH-1:0]  o_err_cnt;
    logic [CNTWIDTH-1:0]  o_first_idx;
    logic [DATAWIDTH-1:0] o_first_meas;
    logic [DATAWIDTH-1:0] o_first_ref;

    modport master (
        output i_valid, i_d_meas, i_d_ref,
        input  o_err, o_done, o_pass, o_state, o_check_cnt, o_err_cnt,
               o_first_idx, o_first_meas, o_first_ref
    );

    modport slave (
        input  i_valid, i_d_meas, i_d_ref,
        output o_err, o_done, o_pass, o_state, o_check_cnt, o_err_cnt,
               o_first_idx, o_first_meas, o_first_ref
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);
    // count up on inc, hold once every bit is set, clear on active-low reset
    always_ff @(posedge clk) begin
        if (!rst) q <= '0;
        else if (inc && q != '1) q <= q + 1'b1;
    end
endmodule

// File: rtl/result_checker.sv
// result_checker: compares measured against reference samples and tracks pass/fail of a run
module result_checker
    import result_checker_pkg::*;
#(
    parameter int DATAWIDTH  = 32,
    parameter int CNTWIDTH   = 16,
    parameter int NUM_CHECKS = 1000,
    parameter int MAX_ERRORS = 16
) (
    input logic              clk,
    input logic              rst,
    result_checker_if.slave  bus
);
    logic                 w_accept;
    logic                 w_mis;
    logic                 w_last;
    logic [STATE_W-1:0]   w_state_nxt;
    logic [CNTWIDTH-1:0]  w_check_cnt;
    logic [CNTWIDTH-1:0]  w_err_cnt;
    logic [STATE_W-1:0]   r_state;
    logic                 r_err;
    logic                 r_done;
    logic                 r_pass;
    logic [CNTWIDTH-1:0]  r_first_idx;
    logic [DATAWIDTH-1:0] r_first_meas;
    logic [DATAWIDTH-1:0] r_first_ref;

    assign w_accept = bus.i_valid && r_state != ST_DONE;
    assign w_mis    = w_accept && bus.i_d_meas != bus.i_d_ref;
    // the run ends on the sample that brings either count to its limit; compared in 32 bits so a
    // saturated counter narrower than the limit can never falsely match a truncated constant
    assign w_last   = w_accept && (int'(w_check_cnt) + 1 == NUM_CHECKS ||
                                   (w_mis && int'(w_err_cnt) + 1 == MAX_ERRORS));

    sat_counter #(.WIDTH(CNTWIDTH)) u_check_cnt (.clk(clk), .rst(rst), .inc(w_accept), .q(w_check_cnt));
    sat_counter #(.WIDTH(CNTWIDTH)) u_err_cnt   (.clk(clk), .rst(rst), .inc(w_mis),    .q(w_err_cnt));

    // next state: limit reached wins over a mismatch, a mismatch wins over a plain first sample
    always_comb begin
        w_state_nxt = w_last ? ST_DONE :
                      w_mis ? ST_FAIL :
                      (w_accept && r_state == ST_IDLE) ? ST_RUN : r_state;
    end

    // state, sticky flags and first-mismatch capture; done/pass follow the next state so they line up with it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_first_idx  <= '0;
            r_first_meas <= '0;
            r_first_ref  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= r_err | w_mis;
            r_done  <= w_state_nxt == ST_DONE;
            r_pass  <= w_state_nxt == ST_DONE && !(r_err | w_mis);
            if (w_mis && !r_err) begin
                r_first_idx  <= w_check_cnt;
                r_first_meas <= bus.i_d_meas;
                r_first_ref  <= bus.i_d_ref;
            end
        end
    end

    assign bus.o_state      = r_state;
    assign bus.o_err        = r_err;
    assign bus.o_done       = r_done;
    assign bus.o_pass       = r_pass;
    assign bus.o_check_cnt  = w_check_cnt;
    assign bus.o_err_cnt    = w_err_cnt;
    assign bus.o_first_idx  = r_first_idx;
    assign bus.o_first_meas = r_first_meas;
    assign bus.o_first_ref  = r_first_ref;
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: scoreboard bench driving three checker configurations with one stimulus stream
module tb_result_checker;

    typedef struct {
        int          st;
        bit          err;
        int          chk;
        int          ec;
        int          fi;
        logic [31:0] fm;
        logic [31:0] fr;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    mdl_t m [3];
    mdl_t exp_q [$];
    int   nc [3] = '{8, 8, 100};
    int   me [3] = '{16, 2, 100};
    int   mx [3] = '{65535, 65535, 7};

    always #5 clk = ~clk;

    result_checker_if #(.DATAWIDTH(32), .CNTWIDTH(16)) if_a ();
    result_checker_if #(.DATAWIDTH(32), .CNTWIDTH(16)) if_b ();
    result_checker_if #(.DATAWIDTH(32), .CNTWIDTH(3))  if_c ();

    result_checker #(.DATAWIDTH(32), .CNTWIDTH(16), .NUM_CHECKS(8), .MAX_ERRORS(16))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    result_checker #(.DATAWIDTH(32), .CNTWIDTH(16), .NUM_CHECKS(8), .MAX_ERRORS(2))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    result_checker #(.DATAWIDTH(32), .CNTWIDTH(3), .NUM_CHECKS(100), .MAX_ERRORS(100))
        dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic mdl_t mstep(input mdl_t p, input bit r, input bit v,
                                   input logic [31:0] dm, input logic [31:0] dr,
                                   input int n_chk, input int n_err, input int n_max);
        mdl_t n;
        bit   mis;
        n = p;
        if (!r) begin
            n = '{default: 0};
            return n;
        end
        if (!v || p.st == 3) return n;
        mis = dm !== dr;
        if (mis && !p.err) begin
            n.fi = p.chk;
            n.fm = dm;
            n.fr = dr;
        end
        if (p.chk < n_max) n.chk = p.chk + 1;
        if (mis && p.ec < n_max) n.ec = p.ec + 1;
        n.err = p.err | mis;
        n.st  = (n.chk == n_chk || n.ec == n_err) ? 3 : n.err ? 2 : 1;
        return n;
    endfunction

    task automatic cmp(input string nm, input mdl_t e, input logic [1:0] st, input logic er,
                       input logic dn, input logic ps, input logic [15:0] cc, input logic [15:0] ec,
                       input logic [15:0] fi, input logic [31:0] fm, input logic [31:0] fr);
        check_val({nm, ".state"},      64'(st), 64'(e.st));
        check_val({nm, ".err"},        64'(er), 64'(e.err));
        check_val({nm, ".done"},       64'(dn), 64'(e.st == 3));
        check_val({nm, ".pass"},       64'(ps), 64'(e.st == 3 && !e.err));
        check_val({nm, ".check_cnt"},  64'(cc), 64'(e.chk));
        check_val({nm, ".err_cnt"},    64'(ec), 64'(e.ec));
        check_val({nm, ".first_idx"},  64'(fi), 64'(e.fi));
        check_val({nm, ".first_meas"}, 64'(fm), 64'(e.fm));
        check_val({nm, ".first_ref"},  64'(fr), 64'(e.fr));
    endtask

    task automatic step(input bit r, input bit v, input logic [31:0] dm, input logic [31:0] dr);
        rst = r;
        if_a.i_valid = v; if_a.i_d_meas = dm; if_a.i_d_ref = dr;
        if_b.i_valid = v; if_b.i_d_meas = dm; if_b.i_d_ref = dr;
        if_c.i_valid = v; if_c.i_d_meas = dm; if_c.i_d_ref = dr;
        for (int k = 0; k < 3; k++) begin
            m[k] = mstep(m[k], r, v, dm, dr, nc[k], me[k], mx[k]);
            exp_q.push_back(m[k]);
        end
        @(posedge clk);
        #1;
        cmp("A", exp_q.pop_front(), if_a.o_state, if_a.o_err, if_a.o_done, if_a.o_pass,
            if_a.o_check_cnt, if_a.o_err_cnt, if_a.o_first_idx, if_a.o_first_meas, if_a.o_first_ref);
        cmp("B", exp_q.pop_front(), if_b.o_state, if_b.o_err, if_b.o_done, if_b.o_pass,
            if_b.o_check_cnt, if_b.o_err_cnt, if_b.o_first_idx, if_b.o_first_meas, if_b.o_first_ref);
        cmp("C", exp_q.pop_front(), if_c.o_state, if_c.o_err, if_c.o_done, if_c.o_pass,
            16'(if_c.o_check_cnt), 16'(if_c.o_err_cnt), 16'(if_c.o_first_idx),
            if_c.o_first_meas, if_c.o_first_ref);
    endtask

    initial begin
        logic [31:0] dm;
        logic [31:0] dr;
        for (int k = 0; k < 3; k++) m[k] = '{default: 0};
        // held in reset with live mismatching samples
        for (int i = 0; i < 10; i++) step(0, 1, 1, 2);
        // eight clean samples: A and B finish passing, C keeps counting until it saturates
        for (int i = 0; i < 8; i++) step(1, 1, i + 1, i + 1);
        step(1, 1, 7, 8);
        // mismatches at samples 3 and 5
        step(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            dm = i + 1;
            dr = i + 1;
            if (i == 3) begin dm = 5; dr = 4; end
            if (i == 5) begin dm = 9; dr = 7; end
            step(1, 1, dm, dr);
        end
        step(1, 1, 3, 3);
        // two leading mismatches end B early; later samples must not disturb it
        step(0, 0, 0, 0);
        step(1, 1, 1, 2);
        step(1, 1, 3, 4);
        for (int i = 0; i < 3; i++) step(1, 1, i, i + 1);
        // valid toggling with garbage data on the idle cycles
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, i % 2, i, (i % 2) ? i : i + 100);
        // reset in the middle of a failing run, then a fresh run
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 10 + i, 20 + i);
        step(1, 1, 4, 4);
        step(0, 1, 1, 2);
        for (int i = 0; i < 4; i++) step(1, 1, i, i);
        // long mismatch burst to drive the narrow counters into saturation
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 32'hFFFF_0000 + i, i);
        // random traffic
        step(0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter DATAWIDTH, default 32, width of the measured and reference data.
REQ-002 Parameter CNTWIDTH, default 16, width of the sample counter and error counter.
REQ-003 Parameter NUM_CHECKS, default 1000, number of valid samples that ends the run.
REQ-004 Parameter MAX_ERRORS, default 16, number of mismatches that ends the run early.
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-low (rst=0 resets on next posedge).
REQ-007 dMeas  input  DATAWIDTH  measured DUT output.
REQ-008 dRef  input  DATAWIDTH  expected value.
REQ-009 valid  input  1  dMeas/dRef pair is to be checked this cycle.
REQ-010 err  output  1  sticky mismatch flag.
REQ-011 done  output  1  run complete.
REQ-012 pass  output  1  done with zero mismatches.
REQ-013 state  output  2  current FSM state encoding.
REQ-014 check_cnt, err_cnt  output  CNTWIDTH each  samples checked; mismatches seen.
REQ-015 first_idx  output  CNTWIDTH  0-based index of the first mismatching sample.
REQ-016 first_meas, first_ref  output  DATAWIDTH each  dMeas/dRef captured at the first mismatch.

Function
REQ-017 A sample is accepted on a posedge where rst=1, valid=1 and state is IDLE, RUN or FAIL; mismatch = (dMeas != dRef) over all DATAWIDTH bits.
REQ-018 All outputs are registered; effects of an accepted sample appear one cycle after its posedge; there is no combinational path from the inputs to the outputs.
REQ-019 FSM states: IDLE=0, RUN=1, FAIL=2, DONE=3.
REQ-020 IDLE: first accepted sample goes to RUN if it matches, FAIL if it mismatches, and is checked like any later sample.
REQ-021 RUN->FAIL on a mismatch; FAIL stays FAIL; RUN or FAIL -> DONE when check_cnt reaches NUM_CHECKS or err_cnt reaches MAX_ERRORS.
REQ-022 Simultaneous case: a mismatch on the NUM_CHECKS-th sample goes to DONE with err=1, err_cnt incremented and pass=0.
REQ-023 DONE is terminal until reset; valid is ignored and all outputs hold.
REQ-024 check_cnt increments per accepted sample; err_cnt increments per mismatch; both saturate at 2^CNTWIDTH-1 without wrapping.
REQ-025 err rises with the first mismatch and stays 1 until reset.
REQ-026 first_idx, first_meas and first_ref load only on the first mismatch, with first_idx = check_cnt before that increment; later mismatches do not overwrite them.
REQ-027 done=1 exactly when state=DONE; pass = done & ~err.
REQ-028 valid=0 cycles change nothing, whatever the data inputs hold.

Reset
REQ-029 On any posedge with rst=0: state=IDLE; err, done, pass=0; all counters and capture registers=0; this applies in any state, including mid-run.
REQ-030 Inputs are ignored while rst=0; the first sample can be accepted on the first posedge with rst=1.

Structure
REQ-031 Shared package result_checker_pkg holds the state encodings (IDLE/RUN/FAIL/DONE) and the state width constant.
REQ-032 One sub-module, sat_counter (parameter WIDTH; inputs clk, rst, inc; output q, saturating), is instantiated twice: for check_cnt and for err_cnt.

Verification
REQ-033 rst=0 for 10 cycles with valid=1, dMeas=1, dRef=2 -> all outputs 0, state=0 throughout.
REQ-034 NUM_CHECKS=8, 8 back-to-back samples dMeas=dRef=i+1 -> one cycle after the 8th: done=1, pass=1, err=0, check_cnt=8, state=3.
REQ-035 Mismatch at sample 3 (dMeas=5, dRef=4), then a mismatch at sample 5 (dMeas=9, dRef=7) -> err=1 one cycle after sample 3; first_idx=3, first_meas=5, first_ref=4 unchanged after sample 5; err_cnt=2.
REQ-036 MAX_ERRORS=2, mismatches on samples 0 and 1 -> done=1, pass=0, check_cnt=2; further valid samples leave all outputs unchanged.
REQ-037 valid toggling 0/1 with mismatching data on the valid=0 cycles -> only valid=1 cycles counted, err stays 0.
REQ-038 rst=0 for one cycle while in FAIL (err_cnt=3) -> next cycle all outputs 0 and state=IDLE; a new run then counts from 0.
